// File: rtl/pc_gen_pkg.sv
// Shared definitions for the rysy fetch PC generator: datapath width, PC step,
// default reset vector, FSM state encoding and the target alignment helper.
package pc_gen_pkg;

  localparam int REG_LEN = 32;
  localparam logic [REG_LEN-1:0] PC_STEP          = 32'd4;
  localparam logic [REG_LEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [REG_LEN-1:0] PC_ALIGN_MASK    = 32'h0000_0003;

  typedef enum logic {
    PCG_RUN   = 1'b0,
    PCG_FLUSH = 1'b1
  } pcg_state_t;

  // Instruction fetch is word-aligned; the two low bits of a target are dropped.
  function automatic logic [REG_LEN-1:0] align_pc(input logic [REG_LEN-1:0] target);
    return target & ~PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch/redirect bus between execute (master) and the PC generator (slave).
// Optional misalign_err signal exists only when PC_MISALIGN_TRAP_EN is defined.
interface pc_gen_if;
  import pc_gen_pkg::*;

  // Handshake: jump_req is a single-cycle request with no ready/backpressure.
  // In RUN it is accepted on the edge where it is high, even when stall is
  // high; in FLUSH it is dropped because it comes from a wrong-path slot.
  logic               stall;
  logic               jump_req;
  logic [REG_LEN-1:0] jump_target;
  logic [REG_LEN-1:0] pc;
  logic [REG_LEN-1:0] pc_next;
  logic               kill;
  logic               jump_taken;
  pcg_state_t         state;
`ifdef PC_MISALIGN_TRAP_EN
  logic               misalign_err;
`endif

  modport master (
`ifdef PC_MISALIGN_TRAP_EN
    input  misalign_err,
`endif
    output stall, jump_req, jump_target,
    input  pc, pc_next, kill, jump_taken, state
  );

  modport slave (
`ifdef PC_MISALIGN_TRAP_EN
    output misalign_err,
`endif
    input  stall, jump_req, jump_target,
    output pc, pc_next, kill, jump_taken, state
  );

endinterface

// File: rtl/pc_gen.sv
// Program-counter generator and redirect unit: PC += 4, ALU redirects, and a
// PIPE_DEPTH-cycle kill window. Optional PC_MISALIGN_TRAP_EN traps misaligned targets.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [REG_LEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                 PIPE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_gen_if.slave      bus
);

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

  pcg_state_t         state, state_d;
  logic [CNT_W-1:0]   kill_cnt, kill_cnt_d;
  logic [REG_LEN-1:0] pc_q, pc_d;
  logic               kill_q;
  logic               jump_taken_q, jump_taken_d;
  logic               target_ok;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign target_ok  = (bus.jump_target & PC_ALIGN_MASK) == '0;
  assign misalign_d = (state == PCG_RUN) && bus.jump_req && !target_ok;
`else
  assign target_ok  = 1'b1;
`endif

  always_comb begin
    pc_d         = pc_q;
    kill_cnt_d   = kill_cnt;
    state_d      = state;
    jump_taken_d = 1'b0;
    unique case (state)
      PCG_RUN: begin
        if (bus.jump_req) begin
          // A rejected (misaligned) request leaves pc where it is, even unstalled.
          if (target_ok) begin
            pc_d         = align_pc(bus.jump_target);
            kill_cnt_d   = CNT_W'(PIPE_DEPTH);
            state_d      = PCG_FLUSH;
            jump_taken_d = 1'b1;
          end
        end else if (!bus.stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      PCG_FLUSH: begin
        if (!bus.stall) begin
          pc_d       = pc_q + PC_STEP;
          kill_cnt_d = kill_cnt - CNT_W'(1);
          if (kill_cnt == CNT_W'(1)) state_d = PCG_RUN;
        end
      end
      default: state_d = PCG_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PCG_RUN;
      kill_cnt     <= '0;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      jump_taken_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      kill_cnt     <= kill_cnt_d;
      pc_q         <= pc_d;
      kill_q       <= (kill_cnt_d != '0);
      jump_taken_q <= jump_taken_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_next    = pc_d;
  assign bus.kill       = kill_q;
  assign bus.jump_taken = jump_taken_q;
  assign bus.state      = state;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, redirect, stalls in flush, wrong-path jumps,
// wrap/alignment (or the misalign trap when PC_MISALIGN_TRAP_EN is defined), async reset.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_gen_if bus ();

  pc_gen #(.RESET_PC(32'h0000_0000), .PIPE_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock and land 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; bus.stall = 1'b0; bus.jump_req = 1'b0; bus.jump_target = '0;
    #1 rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
    n_checks++; if (bus.kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill: got %b want 0", bus.kill); end
    n_checks++; if (bus.jump_taken !== 1'b0) begin n_fail++; $display("FAIL reset_jt: got %b want 0", bus.jump_taken); end
    n_checks++; if (bus.state !== PCG_RUN) begin n_fail++; $display("FAIL reset_state: got %0d want RUN", bus.state); end
`ifdef PC_MISALIGN_TRAP_EN
    n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.misalign_err); end
`endif
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.pc_next !== 32'h4) begin n_fail++; $display("FAIL reset_pc_next: got %h want %h", bus.pc_next, 32'h4); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (bus.pc !== 32'(4 * i)) begin n_fail++; $display("FAIL reset_seq_pc%0d: got %h want %h", i, bus.pc, 32'(4 * i)); end
      n_checks++; if (bus.kill !== 1'b0) begin n_fail++; $display("FAIL reset_seq_kill%0d: got %b want 0", i, bus.kill); end
    end
  endtask

  task automatic test_jump();
    tick();
    n_checks++; if (bus.pc !== 32'h10) begin n_fail++; $display("FAIL jump_pre_pc: got %h want %h", bus.pc, 32'h10); end
    bus.jump_req = 1'b1; bus.jump_target = 32'h200;
    #1;
    n_checks++; if (bus.pc_next !== 32'h200) begin n_fail++; $display("FAIL jump_pc_next: got %h want %h", bus.pc_next, 32'h200); end
    tick();
    bus.jump_req = 1'b0;
    n_checks++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL jump_pc0: got %h want %h", bus.pc, 32'h200); end
    n_checks++; if (bus.jump_taken !== 1'b1) begin n_fail++; $display("FAIL jump_jt0: got %b want 1", bus.jump_taken); end
    n_checks++; if (bus.kill !== 1'b1) begin n_fail++; $display("FAIL jump_kill0: got %b want 1", bus.kill); end
    n_checks++; if (bus.state !== PCG_FLUSH) begin n_fail++; $display("FAIL jump_state0: got %0d want FLUSH", bus.state); end
    tick();
    n_checks++; if (bus.pc !== 32'h204) begin n_fail++; $display("FAIL jump_pc1: got %h want %h", bus.pc, 32'h204); end
    n_checks++; if (bus.kill !== 1'b1) begin n_fail++; $display("FAIL jump_kill1: got %b want 1", bus.kill); end
    n_checks++; if (bus.jump_taken !== 1'b0) begin n_fail++; $display("FAIL jump_jt1: got %b want 0", bus.jump_taken); end
    tick();
    n_checks++; if (bus.pc !== 32'h208) begin n_fail++; $display("FAIL jump_pc2: got %h want %h", bus.pc, 32'h208); end
    n_checks++; if (bus.kill !== 1'b0) begin n_fail++; $display("FAIL jump_kill2: got %b want 0", bus.kill); end
    n_checks++; if (bus.state !== PCG_RUN) begin n_fail++; $display("FAIL jump_state2: got %0d want RUN", bus.state); end
  endtask

  task automatic test_stall_in_flush();
    bus.jump_req = 1'b1; bus.jump_target = 32'h100;
    tick();
    bus.jump_req = 1'b0;
    n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL sflush_pc0: got %h want %h", bus.pc, 32'h100); end
    tick();
    n_checks++; if (bus.pc !== 32'h104) begin n_fail++; $display("FAIL sflush_pc1: got %h want %h", bus.pc, 32'h104); end
    bus.stall = 1'b1;
    #1;
    n_checks++; if (bus.pc_next !== 32'h104) begin n_fail++; $display("FAIL sflush_pc_next: got %h want %h", bus.pc_next, 32'h104); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.pc !== 32'h104) begin n_fail++; $display("FAIL sflush_hold_pc%0d: got %h want %h", i, bus.pc, 32'h104); end
      n_checks++; if (bus.kill !== 1'b1) begin n_fail++; $display("FAIL sflush_hold_kill%0d: got %b want 1", i, bus.kill); end
    end
    bus.stall = 1'b0;
    tick();
    n_checks++; if (bus.pc !== 32'h108) begin n_fail++; $display("FAIL sflush_pc_end: got %h want %h", bus.pc, 32'h108); end
    n_checks++; if (bus.kill !== 1'b0) begin n_fail++; $display("FAIL sflush_kill_end: got %b want 0", bus.kill); end
    n_checks++; if (bus.state !== PCG_RUN) begin n_fail++; $display("FAIL sflush_state_end: got %0d want RUN", bus.state); end
  endtask

  task automatic test_wrong_path();
    bus.jump_req = 1'b1; bus.jump_target = 32'h300;
    tick();
    n_checks++; if (bus.pc !== 32'h300) begin n_fail++; $display("FAIL wpath_pc0: got %h want %h", bus.pc, 32'h300); end
    bus.jump_target = 32'h400;
    #1;
    n_checks++; if (bus.pc_next !== 32'h304) begin n_fail++; $display("FAIL wpath_pc_next: got %h want %h", bus.pc_next, 32'h304); end
    tick();
    n_checks++; if (bus.pc !== 32'h304) begin n_fail++; $display("FAIL wpath_pc1: got %h want %h", bus.pc, 32'h304); end
    n_checks++; if (bus.jump_taken !== 1'b0) begin n_fail++; $display("FAIL wpath_jt1: got %b want 0", bus.jump_taken); end
    n_checks++; if (bus.kill !== 1'b1) begin n_fail++; $display("FAIL wpath_kill1: got %b want 1", bus.kill); end
    tick();
    bus.jump_req = 1'b0;
    n_checks++; if (bus.pc !== 32'h308) begin n_fail++; $display("FAIL wpath_pc2: got %h want %h", bus.pc, 32'h308); end
    n_checks++; if (bus.jump_taken !== 1'b0) begin n_fail++; $display("FAIL wpath_jt2: got %b want 0", bus.jump_taken); end
    n_checks++; if (bus.kill !== 1'b0) begin n_fail++; $display("FAIL wpath_kill2: got %b want 0", bus.kill); end
  endtask

  task automatic test_stall_run();
    bus.stall = 1'b1;
    tick();
    n_checks++; if (bus.pc !== 32'h308) begin n_fail++; $display("FAIL srun_hold: got %h want %h", bus.pc, 32'h308); end
    bus.jump_req = 1'b1; bus.jump_target = 32'h40;
    #1;
    n_checks++; if (bus.pc_next !== 32'h40) begin n_fail++; $display("FAIL srun_pc_next: got %h want %h", bus.pc_next, 32'h40); end
    tick();
    bus.jump_req = 1'b0;
    n_checks++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL srun_jump_pc: got %h want %h", bus.pc, 32'h40); end
    n_checks++; if (bus.jump_taken !== 1'b1) begin n_fail++; $display("FAIL srun_jump_jt: got %b want 1", bus.jump_taken); end
    tick();
    n_checks++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL srun_flush_hold: got %h want %h", bus.pc, 32'h40); end
    n_checks++; if (bus.kill !== 1'b1) begin n_fail++; $display("FAIL srun_flush_kill: got %b want 1", bus.kill); end
    bus.stall = 1'b0;
    tick();
    n_checks++; if (bus.pc !== 32'h44) begin n_fail++; $display("FAIL srun_pc44: got %h want %h", bus.pc, 32'h44); end
    tick();
    n_checks++; if (bus.pc !== 32'h48) begin n_fail++; $display("FAIL srun_pc48: got %h want %h", bus.pc, 32'h48); end
    n_checks++; if (bus.kill !== 1'b0) begin n_fail++; $display("FAIL srun_kill_end: got %b want 0", bus.kill); end
  endtask

  task automatic test_wrap_align();
    bus.jump_req = 1'b1; bus.jump_target = 32'hFFFF_FFFE;
`ifdef PC_MISALIGN_TRAP_EN
    #1;
    n_checks++; if (bus.pc_next !== 32'h48) begin n_fail++; $display("FAIL trap_pc_next: got %h want %h", bus.pc_next, 32'h48); end
    tick();
    bus.jump_req = 1'b0;
    n_checks++; if (bus.pc !== 32'h48) begin n_fail++; $display("FAIL trap_pc_hold: got %h want %h", bus.pc, 32'h48); end
    n_checks++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL trap_err: got %b want 1", bus.misalign_err); end
    n_checks++; if (bus.kill !== 1'b0) begin n_fail++; $display("FAIL trap_kill: got %b want 0", bus.kill); end
    n_checks++; if (bus.jump_taken !== 1'b0) begin n_fail++; $display("FAIL trap_jt: got %b want 0", bus.jump_taken); end
    tick();
    n_checks++; if (bus.pc !== 32'h4C) begin n_fail++; $display("FAIL trap_pc_next_cycle: got %h want %h", bus.pc, 32'h4C); end
    n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL trap_err_pulse: got %b want 0", bus.misalign_err); end
`else
    #1;
    n_checks++; if (bus.pc_next !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc_next: got %h want %h", bus.pc_next, 32'hFFFF_FFFC); end
    tick();
    bus.jump_req = 1'b0;
    n_checks++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_align_pc: got %h want %h", bus.pc, 32'hFFFF_FFFC); end
    n_checks++; if (bus.jump_taken !== 1'b1) begin n_fail++; $display("FAIL wrap_jt: got %b want 1", bus.jump_taken); end
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc0: got %h want %h", bus.pc, 32'h0); end
    n_checks++; if (bus.kill !== 1'b1) begin n_fail++; $display("FAIL wrap_kill: got %b want 1", bus.kill); end
    tick();
    n_checks++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL wrap_pc4: got %h want %h", bus.pc, 32'h4); end
    n_checks++; if (bus.kill !== 1'b0) begin n_fail++; $display("FAIL wrap_kill_end: got %b want 0", bus.kill); end
`endif
  endtask

  task automatic test_async_reset();
    bus.jump_req = 1'b1; bus.jump_target = 32'h80;
    tick();
    bus.jump_req = 1'b0;
    tick();
    n_checks++; if (bus.pc !== 32'h84) begin n_fail++; $display("FAIL areset_pre_pc: got %h want %h", bus.pc, 32'h84); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.kill !== 1'b0) begin n_fail++; $display("FAIL areset_kill: got %b want 0", bus.kill); end
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL areset_pc: got %h want %h", bus.pc, 32'h0); end
    n_checks++; if (bus.state !== PCG_RUN) begin n_fail++; $display("FAIL areset_state: got %0d want RUN", bus.state); end
    #1 rst_n = 1'b1;
    tick();
    n_checks++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL areset_after_pc: got %h want %h", bus.pc, 32'h4); end
    n_checks++; if (bus.kill !== 1'b0) begin n_fail++; $display("FAIL areset_after_kill: got %b want 0", bus.kill); end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_stall_in_flush();
    test_wrong_path();
    test_stall_run();
    test_wrap_align();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter generator and redirect unit for the rysy core.
- Owns the architectural fetch PC and advances it by 4 each cycle.
- Accepts the ALU-computed jump/branch target back from execute; this closes the loop in which the delayed PC is fed into the ALU.
- On a redirect it loads the target and asserts a kill window of PIPE_DEPTH cycles, so decode/execute drop the wrong-path instructions already in flight.

Parameters:
- REG_LEN, 32: PC/data width; comes from the shared package.
- RESET_PC, 32'h0000_0000: PC value after reset.
- PIPE_DEPTH, 2: number of wrong-path instructions in flight behind a jump; kill window length; range 1..7.

Ports:
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and kill counter this cycle (memory or hazard stall).
- jump_req  in  1  execute requests redirect this cycle.
- jump_target  in  REG_LEN  ALU result used as the new PC.
- pc  out  REG_LEN  current fetch address, registered.
- pc_next  out  REG_LEN  combinational value pc takes at the next edge.
- kill  out  1  current decode/execute instruction is wrong-path; registered.
- jump_taken  out  1  one-cycle pulse, the cycle after an accepted redirect.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC; state = RUN; kill_cnt = 0; kill = 0; jump_taken = 0.
- States:
  - RUN: no kill window active.
  - FLUSH: kill_cnt != 0.
- RUN:
  - jump_req=1: accepted regardless of stall. pc <= aligned target; kill_cnt <= PIPE_DEPTH; state <= FLUSH; jump_taken <= 1.
  - else stall=1: pc held.
  - else: pc <= pc + 4.
- FLUSH:
  - kill = 1 for every cycle with kill_cnt != 0.
  - jump_req is ignored, because it comes from a wrong-path instruction. No pc load and no jump_taken.
  - stall=0: pc <= pc + 4; kill_cnt <= kill_cnt - 1. When kill_cnt reaches 0, state <= RUN.
  - stall=1: pc and kill_cnt held; kill stays 1.
- Timing: a jump_req seen at edge N gives pc = target, kill = 1 and jump_taken = 1 after edge N. With no stalls, kill stays high for exactly PIPE_DEPTH cycles.
- Alignment: target bits [1:0] are forced to 0 before loading.
- Arithmetic: pc + 4 is modulo 2^REG_LEN, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- pc_next always equals the value pc will take at the next edge, given the current inputs.
- Reset mid-FLUSH: kill_cnt clears immediately, kill drops asynchronously, and pc = RESET_PC.
- kill_cnt is sized as $clog2(PIPE_DEPTH+1) bits.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_err (1 bit, registered).
  - An accepted jump_req with jump_target[1:0] != 0 does not redirect: pc holds, no FLUSH, jump_taken = 0.
  - misalign_err pulses 1 for one cycle.
  - Otherwise the block behaves as in Behaviour.
- Undefined:
  - No misalign_err port.
  - Low bits are silently masked as described in Behaviour.

Decomposition:
- Shared package (rysy_pkg.vh):
  - REG_LEN.
  - PC_STEP (4).
  - Default RESET_PC.
  - State encodings PCG_RUN and PCG_FLUSH.
- No sub-module. The kill counter is a few lines and stays inline; a separate module adds no reuse.

Test Plan:
- Reset: hold rst_n=0 then release, stall=0, no jumps -> pc = 0x0, 0x4, 0x8, 0xC on successive cycles; kill = 0 throughout.
- Jump: at pc=0x10, pulse jump_req with target 0x200 -> next cycle pc=0x200, jump_taken=1, kill=1. Following cycle pc=0x204, kill=1. Then pc=0x208, kill=0.
- Stall inside flush: jump to 0x100, then stall=1 for 3 cycles on the 2nd kill cycle -> pc holds 0x104 and kill stays 1 for all 3 cycles. After release, one more kill cycle, then RUN.
- Wrong-path jump: during FLUSH assert jump_req with target 0x400 -> ignored; pc continues +4 from the first target; jump_taken stays 0.
- Wrap and alignment: jump to 0xFFFF_FFFE -> pc = 0xFFFF_FFFC, then 0x0000_0000. With PC_MISALIGN_TRAP_EN defined instead: pc holds, misalign_err pulses 1, no kill.
- Async reset mid-flush: drop rst_n while kill_cnt=1 between edges -> kill=0 and pc=RESET_PC before the next clk edge.
